wordboard_seq: RTL and testbench
================================

WORDBOARD_SEQ -- requirements
Module: wordboard_seq

Interface
REQ-001 The module SHALL have parameter SW_W, default 4, meaning switch/word width in bits (1..16).
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning number of stored words (2..64).
REQ-003 The module SHALL have parameter BIT_TICKS, default 50000, meaning sysclk cycles per output bit period (>=2; 1 ms at 50 MHz).
REQ-004 The module SHALL have parameter DEB_TICKS, default 100000, meaning consecutive stable sysclk cycles required to accept a button level (>=1).
REQ-005 The module SHALL have parameter REPEAT, default 0, meaning 0 = single pass, 1 = loop the stored sequence until stopped.
REQ-006 The module SHALL have port sysclk  input  1  the single clock; all logic is rising-edge.
REQ-007 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-008 The module SHALL have port sw  input  SW_W  word value to store; asynchronous, sampled only on a write event.
REQ-009 The module SHALL have port btn_write  input  1  raw push button, append word.
REQ-010 The module SHALL have port btn_auto  input  1  raw push button, start/stop playback.
REQ-011 The module SHALL have port btn_clear  input  1  raw push button, empty memory / abort.
REQ-012 The module SHALL have port out  output  1  registered serial output.
REQ-013 The module SHALL have port busy  output  1  high while playback is active.
REQ-014 The module SHALL have port full  output  1  high when count equals DEPTH.
REQ-015 The module SHALL have port count  output  clog2(DEPTH+1)  number of stored words.

Function
REQ-016 Each button SHALL pass through a 2-flop synchroniser, then a debouncer that updates its debounced level only after DEB_TICKS consecutive cycles at the new level; any change restarts the count.
REQ-017 A debounced 0->1 transition SHALL produce exactly one single-cycle event pulse; holding a button SHALL produce no further events.
REQ-018 On a write event, when not busy and not full, the module SHALL store sw into mem[count] and increment count; otherwise the event is ignored and memory is unchanged.
REQ-019 On a clear event while idle, count SHALL become 0; while busy, playback SHALL abort: state IDLE, out=0, busy=0, count=0 on the next cycle.
REQ-020 Playback FSM states SHALL be IDLE, START, DATA, GAP; every non-IDLE state bit lasts exactly BIT_TICKS cycles.
REQ-021 On an auto event in IDLE with count>0, the FSM SHALL enter START with word index 0 and out=1 on the next cycle; with count=0 the event is ignored.
REQ-022 START: out=1 for one bit period, then DATA.
REQ-023 DATA: out SHALL carry the SW_W bits of mem[index], MSB first, one bit period each, then GAP.
REQ-024 GAP: out=0 for two bit periods; then if index<count-1, index increments and the FSM enters START; else if REPEAT=1 and no stop is pending, index returns to 0 and the FSM enters START; else IDLE.
REQ-025 An auto event while busy SHALL set a stop-pending flag; the current word completes, then the FSM enters IDLE regardless of REPEAT.
REQ-026 busy SHALL be high exactly while the state is not IDLE; out SHALL be 0 in IDLE.
REQ-027 Simultaneous events SHALL be prioritised clear > auto > write within the same cycle.
REQ-028 Write events while busy SHALL be ignored, so memory is stable during playback.

Reset
REQ-029 rst_n low SHALL immediately force out=0, busy=0, full=0, count=0, state IDLE, stop-pending=0, all debounced levels 0, and timers 0; mem contents need not be reset.
REQ-030 A button held during reset release SHALL generate no event until it is released and pressed again.

Verification (SW_W=4, DEPTH=2, BIT_TICKS=4, DEB_TICKS=3)
REQ-031 Reset: assert rst_n=0 mid-frame -> out=0, busy=0, count=0 without waiting for a clock edge.
REQ-032 Write sw=1001, then 0110, then 1111 (each press held 10 cycles) -> count=1, then count=2 with full=1, then third press ignored and count stays 2.
REQ-033 Auto with REPEAT=0 -> out = 1,1,0,0,1,0,0 then 1,0,1,1,0,0,0, each bit 4 cycles (56 cycles total); busy falls after the last GAP; count stays 2.
REQ-034 Bounce: btn_write toggles every 2 cycles for 20 cycles then returns to 0 -> no write event and count unchanged.
REQ-035 REPEAT=1: auto press -> sequence loops continuously; second auto press during word 0 -> word 0 completes, then IDLE.
REQ-036 Clear event during DATA -> next cycle out=0, busy=0, count=0; a subsequent auto press is ignored.

Source files
------------

// File: rtl/wordboard_seq.sv
// Word board: debounced buttons append switch words to a small memory and play
// them back as a serial frame stream (start bit, MSB-first data, two-bit gap).
module wordboard_seq #(
  parameter int SW_W      = 4,
  parameter int DEPTH     = 8,
  parameter int BIT_TICKS = 50000,
  parameter int DEB_TICKS = 100000,
  parameter int REPEAT    = 0
) (
  input  logic                       sysclk,
  input  logic                       rst_n,
  input  logic [SW_W-1:0]            sw,
  input  logic                       btn_write,
  input  logic                       btn_auto,
  input  logic                       btn_clear,
  output logic                       out,
  output logic                       busy,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int TICK_W = $clog2(BIT_TICKS);
  localparam int DEB_W  = $clog2(DEB_TICKS + 1);
  localparam int BIT_W  = $clog2(SW_W + 1);

  logic [2:0] btn_raw;
  logic [2:0] evt;
  logic       wr_evt, auto_evt, clr_evt;

  assign btn_raw  = {btn_clear, btn_auto, btn_write};
  assign wr_evt   = evt[0];
  assign auto_evt = evt[1];
  assign clr_evt  = evt[2];

  // Synchronisers come out of reset reading "pressed", and a button only arms
  // once it has been seen released, so a press held across reset never fires.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_reg, sync2_reg, level_reg, armed_reg, evt_reg;
      logic [DEB_W-1:0] deb_cnt_reg;

      always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg   <= 1'b1;
          sync2_reg   <= 1'b1;
          level_reg   <= 1'b0;
          armed_reg   <= 1'b0;
          evt_reg     <= 1'b0;
          deb_cnt_reg <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          evt_reg   <= 1'b0;
          if (sync2_reg != level_reg) begin
            if (deb_cnt_reg == DEB_W'(DEB_TICKS - 1)) begin
              level_reg   <= sync2_reg;
              deb_cnt_reg <= '0;
              evt_reg     <= sync2_reg & armed_reg;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
          end else begin
            deb_cnt_reg <= '0;
            if (!level_reg && !sync2_reg) armed_reg <= 1'b1;
          end
        end
      end

      assign evt[gi] = evt_reg;
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

  state_t            state_reg, state_next;
  logic [TICK_W-1:0] tick_reg, tick_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [SW_W-1:0]   shift_reg, shift_next;
  logic [SW_W-1:0]   rd_data_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              stop_reg, stop_next;
  logic              out_reg, out_next;
  logic              wr_en, end_bit, last_word, full_w;

  logic [SW_W-1:0]   mem [DEPTH];

  assign end_bit   = (tick_reg == TICK_W'(BIT_TICKS - 1));
  assign last_word = ((CNT_W'(idx_reg) + CNT_W'(1)) >= count_reg);
  assign full_w    = (count_reg == CNT_W'(DEPTH));

  // The word under playback is read continuously; START lasts at least two
  // cycles, so the registered read is settled before DATA loads it.
  always_ff @(posedge sysclk) begin
    if (wr_en) mem[count_reg[IDX_W-1:0]] <= sw;
    rd_data_reg <= mem[idx_reg];
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      count_reg <= '0;
      stop_reg  <= 1'b0;
      out_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      count_reg <= count_next;
      stop_reg  <= stop_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    count_next = count_reg;
    stop_next  = stop_reg;
    wr_en      = 1'b0;

    if (state_reg != IDLE) tick_next = end_bit ? '0 : tick_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (clr_evt) begin
          count_next = '0;
        end else if (auto_evt) begin
          if (count_reg != '0) begin
            state_next = START;
            idx_next   = '0;
            tick_next  = '0;
            stop_next  = 1'b0;
          end
        end else if (wr_evt && !full_w) begin
          wr_en      = 1'b1;
          count_next = count_reg + 1'b1;
        end
      end
      START: begin
        if (end_bit) begin
          state_next = DATA;
          shift_next = rd_data_reg;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (end_bit) begin
          if (bit_reg == BIT_W'(SW_W - 1)) begin
            state_next = GAP;
            bit_next   = '0;
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = shift_reg << 1;
          end
        end
      end
      GAP: begin
        if (end_bit) begin
          if (bit_reg == '0) begin
            bit_next = BIT_W'(1);
          end else begin
            bit_next = '0;
            if (stop_reg) begin
              state_next = IDLE;
              stop_next  = 1'b0;
            end else if (!last_word) begin
              idx_next   = idx_reg + 1'b1;
              state_next = START;
            end else if (REPEAT != 0) begin
              idx_next   = '0;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Events during playback: clear aborts outright, auto requests a stop at
    // the end of the current word, writes are dropped.
    if (state_reg != IDLE) begin
      if (clr_evt) begin
        state_next = IDLE;
        count_next = '0;
        stop_next  = 1'b0;
        tick_next  = '0;
        bit_next   = '0;
      end else if (auto_evt && state_next != IDLE) begin
        stop_next = 1'b1;
      end
    end

    out_next = (state_next == START) || ((state_next == DATA) && shift_next[SW_W-1]);
  end

  assign out   = out_reg;
  assign busy  = (state_reg != IDLE);
  assign full  = full_w;
  assign count = count_reg;

endmodule

// File: tb/tb_wordboard_seq.sv
// Bench for wordboard_seq: two instances (single pass and looping) driven by
// button presses, with the serial stream predicted from a queue of stored words.
module tb_wordboard_seq;

  localparam int SW_W      = 4;
  localparam int DEPTH     = 2;
  localparam int BIT_TICKS = 4;
  localparam int DEB_TICKS = 3;
  localparam int WORD_CYC  = BIT_TICKS * (SW_W + 3);

  logic            sysclk = 1'b0;
  logic            rst_n;
  logic [SW_W-1:0] sw0, sw1;
  logic            w0, a0, c0, w1, a1, c1;
  logic            out0, busy0, full0, out1, busy1, full1;
  logic [1:0]      count0, count1;

  int checks = 0;
  int errors = 0;

  logic [SW_W-1:0] model0[$];
  logic [SW_W-1:0] model1[$];

  always #5 sysclk = ~sysclk;

  wordboard_seq #(.SW_W(SW_W), .DEPTH(DEPTH), .BIT_TICKS(BIT_TICKS),
                  .DEB_TICKS(DEB_TICKS), .REPEAT(0)) dut0 (
    .sysclk(sysclk), .rst_n(rst_n), .sw(sw0), .btn_write(w0), .btn_auto(a0),
    .btn_clear(c0), .out(out0), .busy(busy0), .full(full0), .count(count0));

  wordboard_seq #(.SW_W(SW_W), .DEPTH(DEPTH), .BIT_TICKS(BIT_TICKS),
                  .DEB_TICKS(DEB_TICKS), .REPEAT(1)) dut1 (
    .sysclk(sysclk), .rst_n(rst_n), .sw(sw1), .btn_write(w1), .btn_auto(a1),
    .btn_clear(c1), .out(out1), .busy(busy1), .full(full1), .count(count1));

  // Expected serial level k cycles after playback starts: each word is a frame of
  // 1 start bit, SW_W data bits MSB first and 2 gap bits, each BIT_TICKS long.
  function automatic logic exp_bit(input int sel, input int k);
    int n, w, pos;
    logic [SW_W-1:0] word;
    n = (sel == 0) ? model0.size() : model1.size();
    if (n == 0) return 1'b0;
    w    = (k / WORD_CYC) % n;
    pos  = (k % WORD_CYC) / BIT_TICKS;
    word = (sel == 0) ? model0[w] : model1[w];
    if (pos == 0) return 1'b1;
    if (pos <= SW_W) return word[SW_W-pos];
    return 1'b0;
  endfunction

  task automatic set_btn(input int sel, input int b, input logic v);
    if (sel == 0) begin
      if (b == 0) w0 = v; else if (b == 1) a0 = v; else c0 = v;
    end else begin
      if (b == 0) w1 = v; else if (b == 1) a1 = v; else c1 = v;
    end
  endtask

  task automatic press(input int sel, input int b, input int hold);
    @(posedge sysclk); #1;
    set_btn(sel, b, 1'b1);
    repeat (hold) @(posedge sysclk);
    #1;
    set_btn(sel, b, 1'b0);
    repeat (10) @(posedge sysclk);
    @(negedge sysclk);
  endtask

  // Press auto and return at the negedge of the first busy cycle.
  task automatic start_auto(input int sel, output int ok);
    @(posedge sysclk); #1;
    set_btn(sel, 1, 1'b1);
    repeat (6) @(posedge sysclk);
    #1;
    set_btn(sel, 1, 1'b0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if ((sel == 0 ? busy0 : busy1) === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw0 = '0; sw1 = '0;
    w0 = 1'b0; a0 = 1'b0; c0 = 1'b0;
    w1 = 1'b1; a1 = 1'b0; c1 = 1'b0;
    #2;
    checks++;
    if (out0 !== 1'b0 || busy0 !== 1'b0 || count0 !== 2'd0 || full0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got out=%b busy=%b count=%0d full=%b expected all 0", out0, busy0, count0, full0);
    end
    repeat (3) @(posedge sysclk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge sysclk);
    @(negedge sysclk);
    checks++;
    if (count1 !== 2'd0) begin
      errors++;
      $display("FAIL held_through_reset: got count=%0d expected 0", count1);
    end
    w1 = 1'b0;
    repeat (12) @(negedge sysclk);
  endtask

  task automatic test_write(input logic [SW_W-1:0] val);
    logic [1:0] exp_cnt;
    sw0 = val;
    press(0, 0, 10);
    if (model0.size() < DEPTH) model0.push_back(val);
    exp_cnt = 2'(model0.size());
    checks++;
    if (count0 !== exp_cnt) begin
      errors++;
      $display("FAIL write_count sw=%b: got %0d expected %0d", val, count0, exp_cnt);
    end
    checks++;
    if (full0 !== logic'(model0.size() == DEPTH)) begin
      errors++;
      $display("FAIL write_full sw=%b: got %b expected %b", val, full0, model0.size() == DEPTH);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      @(posedge sysclk); #1;
      if (i % 2 == 0) w0 = ~w0;
    end
    w0 = 1'b0;
    repeat (12) @(negedge sysclk);
    checks++;
    if (count0 !== 2'(model0.size())) begin
      errors++;
      $display("FAIL bounce: got count=%0d expected %0d", count0, model0.size());
    end
  endtask

  // Play back words_to_play frames; optional auto (stop) and write presses at
  // cycle stop_k / wr_k, each held 10 cycles.
  task automatic test_playback(input int sel, input int words_to_play, input int stop_k, input int wr_k);
    int   ok, total;
    logic o, b;
    total = words_to_play * WORD_CYC;
    start_auto(sel, ok);
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL play_start dut%0d: got busy=0 expected busy=1 within 20 cycles", sel);
    end else begin
      for (int k = 0; k < total; k++) begin
        if (k > 0) @(negedge sysclk);
        if (k == stop_k) set_btn(sel, 1, 1'b1);
        if (k == stop_k + 10) set_btn(sel, 1, 1'b0);
        if (k == wr_k) set_btn(sel, 0, 1'b1);
        if (k == wr_k + 10) set_btn(sel, 0, 1'b0);
        o = (sel == 0) ? out0 : out1;
        b = (sel == 0) ? busy0 : busy1;
        checks++;
        if (o !== exp_bit(sel, k) || b !== 1'b1) begin
          errors++;
          $display("FAIL play_bit dut%0d k=%0d: got out=%b busy=%b expected out=%b busy=1", sel, k, o, b, exp_bit(sel, k));
        end
      end
      @(negedge sysclk);
      o = (sel == 0) ? out0 : out1;
      b = (sel == 0) ? busy0 : busy1;
      checks++;
      if (o !== 1'b0 || b !== 1'b0) begin
        errors++;
        $display("FAIL play_end dut%0d: got out=%b busy=%b expected 0 0", sel, o, b);
      end
      checks++;
      if ((sel == 0 ? count0 : count1) !== 2'(sel == 0 ? model0.size() : model1.size())) begin
        errors++;
        $display("FAIL play_count dut%0d: got %0d expected %0d", sel, (sel == 0 ? count0 : count1), (sel == 0 ? model0.size() : model1.size()));
      end
    end
    set_btn(sel, 0, 1'b0);
    set_btn(sel, 1, 1'b0);
    repeat (12) @(negedge sysclk);
  endtask

  task automatic test_clear();
    int   ok, kfall;
    logic saw_busy;
    start_auto(0, ok);
    kfall = -1;
    for (int k = 0; k < WORD_CYC; k++) begin
      if (k > 0) @(negedge sysclk);
      if (k == 5) c0 = 1'b1;
      if (busy0 !== 1'b1) begin
        kfall = k;
        break;
      end
    end
    checks++;
    if (ok == 0 || kfall < BIT_TICKS || kfall >= BIT_TICKS * (SW_W + 1)) begin
      errors++;
      $display("FAIL clear_abort: got busy fall at k=%0d expected within DATA k=%0d..%0d", kfall, BIT_TICKS, BIT_TICKS * (SW_W + 1) - 1);
    end
    checks++;
    if (out0 !== 1'b0 || count0 !== 2'd0) begin
      errors++;
      $display("FAIL clear_state: got out=%b count=%0d expected 0 0", out0, count0);
    end
    model0.delete();
    c0 = 1'b0;
    repeat (12) @(negedge sysclk);
    saw_busy = 1'b0;
    a0 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge sysclk);
      if (i == 10) a0 = 1'b0;
      if (busy0 !== 1'b0) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b0 || count0 !== 2'd0) begin
      errors++;
      $display("FAIL auto_when_empty: got busy_seen=%b count=%0d expected 0 0", saw_busy, count0);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 3; it++) begin
      press(0, 2, 10);
      model0.delete();
      checks++;
      if (count0 !== 2'd0) begin
        errors++;
        $display("FAIL rand_clear it=%0d: got count=%0d expected 0", it, count0);
      end
      n = int'($urandom_range(1, DEPTH));
      for (int j = 0; j < n; j++) test_write(SW_W'($urandom));
      if (n == DEPTH) test_write(SW_W'($urandom));
      test_playback(0, n, -100, (n < DEPTH) ? 2 : -100);
    end
  endtask

  task automatic test_repeat();
    logic [SW_W-1:0] val;
    for (int j = 0; j < DEPTH; j++) begin
      val = SW_W'($urandom);
      sw1 = val;
      press(1, 0, 10);
      model1.push_back(val);
      checks++;
      if (count1 !== 2'(model1.size())) begin
        errors++;
        $display("FAIL repeat_write: got count=%0d expected %0d", count1, model1.size());
      end
    end
    // Two full passes, then a stop request early in word 0 of the third pass.
    test_playback(1, 2 * DEPTH + 1, 2 * DEPTH * WORD_CYC + 2, -100);
  endtask

  task automatic test_reset_midframe();
    int ok;
    start_auto(0, ok);
    checks++;
    if (ok == 0 || out0 !== 1'b1) begin
      errors++;
      $display("FAIL midframe_start: got busy_ok=%0d out=%b expected 1 1", ok, out0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out0 !== 1'b0 || busy0 !== 1'b0 || count0 !== 2'd0 || full0 !== 1'b0 || busy1 !== 1'b0 || count1 !== 2'd0) begin
      errors++;
      $display("FAIL midframe_reset: got out=%b busy=%b count=%0d full=%b expected all 0", out0, busy0, count0, full0);
    end
    repeat (2) @(posedge sysclk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write(4'b1001);
    test_bounce();
    test_write(4'b0110);
    test_write(4'b1111);
    test_playback(0, DEPTH, -100, -100);
    test_clear();
    test_random();
    test_repeat();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
